// File: rtl/glitc_trigger_pkg.sv
// rtl/glitc_trigger_pkg.sv - shared types and constants for the trigger threshold servo
package glitc_trigger_pkg;

  localparam int POWERBITS_DEF = 12;
  localparam int THRBITS       = POWERBITS_DEF + 2;

  localparam logic [THRBITS-1:0] INIT_THRESHOLD_DEF = 14'h0800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ADJUST,
    ST_UPDATE,
    ST_HOLDOFF
  } servo_state_t;

endpackage

// File: rtl/glitc_sat_counter.sv
// rtl/glitc_sat_counter.sv - saturating event counter with synchronous clear
module glitc_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_inc
);

  // count_inc folds in this cycle's event so a caller can sample it on the final cycle
  always_comb begin
    count_inc = count;
    if (inc && !(&count)) count_inc = count + WIDTH'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count <= '0;
    else if (clr) count <= '0;
    else          count <= count_inc;
  end

endmodule

// File: rtl/glitc_threshold_servo.sv
// rtl/glitc_threshold_servo.sv - trigger-rate servo driving the comparator threshold and update strobe
module glitc_threshold_servo
  import glitc_trigger_pkg::*;
#(
  parameter int                   POWERBITS      = 12,
  parameter int                   COUNTBITS      = 16,
  parameter int                   HOLDOFF        = 8,
  parameter logic [POWERBITS+1:0] INIT_THRESHOLD = INIT_THRESHOLD_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic                   trig_i,
  input  logic [COUNTBITS-1:0]   window_i,
  input  logic [COUNTBITS-1:0]   target_i,
  input  logic [COUNTBITS-1:0]   deadband_i,
  input  logic [POWERBITS+1:0]   step_i,
  input  logic [POWERBITS+1:0]   thr_min_i,
  input  logic [POWERBITS+1:0]   thr_max_i,
  input  logic                   manual_load_i,
  input  logic [POWERBITS+1:0]   manual_threshold_i,
  output logic [POWERBITS+1:0]   threshold_o,
  output logic                   threshold_update_o,
  output logic [COUNTBITS-1:0]   scaler_o,
  output logic                   busy_o
);

  localparam int TW = POWERBITS + 2;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  servo_state_t         state;
  logic [COUNTBITS-1:0] win_cnt, win_end, trig_cnt, trig_cnt_inc;
  logic [HW-1:0]        ho_cnt;
  logic [TW-1:0]        pend_thr, adj_thr, up_val, dn_val, dn_diff, upd_val;
  logic [TW:0]          up_sum;
  logic [COUNTBITS:0]   hi_lim, lo_sum;
  logic                 pend_valid, win_last, ho_last, rate_hi, rate_lo, upd_req;

  glitc_sat_counter #(.WIDTH(COUNTBITS)) u_trig_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr       (state != ST_COUNT),
    .inc       (trig_i),
    .count     (trig_cnt),
    .count_inc (trig_cnt_inc)
  );

  always_comb begin
    win_end  = (window_i == '0) ? '0 : window_i - COUNTBITS'(1);
    win_last = (win_cnt == win_end);
    ho_last  = (ho_cnt == HW'(HOLDOFF - 1));

    hi_lim  = {1'b0, target_i} + {1'b0, deadband_i};
    lo_sum  = {1'b0, scaler_o} + {1'b0, deadband_i};
    rate_hi = ({1'b0, scaler_o} > hi_lim);
    rate_lo = (lo_sum < {1'b0, target_i});

    up_sum  = {1'b0, threshold_o} + {1'b0, step_i};
    up_val  = (up_sum > {1'b0, thr_max_i}) ? thr_max_i : up_sum[TW-1:0];
    dn_diff = threshold_o - step_i;
    dn_val  = (threshold_o < step_i || dn_diff < thr_min_i) ? thr_min_i : dn_diff;
    adj_thr = rate_hi ? up_val : (rate_lo ? dn_val : threshold_o);

    // Every path to UPDATE funnels through here; a manual request always outranks the servo
    upd_req = 1'b0;
    upd_val = manual_threshold_i;
    case (state)
      ST_IDLE, ST_COUNT: upd_req = manual_load_i;
      ST_ADJUST: begin
        upd_req = manual_load_i || (adj_thr != threshold_o);
        if (!manual_load_i) upd_val = adj_thr;
      end
      ST_HOLDOFF: begin
        upd_req = ho_last && (manual_load_i || pend_valid);
        if (!manual_load_i) upd_val = pend_thr;
      end
      default: upd_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state              <= ST_IDLE;
      threshold_o        <= INIT_THRESHOLD;
      threshold_update_o <= 1'b0;
      scaler_o           <= '0;
      busy_o             <= 1'b0;
      win_cnt            <= '0;
      ho_cnt             <= '0;
      pend_valid         <= 1'b0;
      pend_thr           <= '0;
    end else begin
      threshold_update_o <= 1'b0;
      busy_o             <= 1'b0;
      win_cnt            <= '0;
      ho_cnt             <= '0;
      if (upd_req) begin
        threshold_o        <= upd_val;
        threshold_update_o <= 1'b1;
        busy_o             <= 1'b1;
        pend_valid         <= 1'b0;
        state              <= ST_UPDATE;
      end else begin
        case (state)
          ST_IDLE: if (enable_i) state <= ST_COUNT;
          ST_COUNT: begin
            if (!enable_i) begin
              state <= ST_IDLE;
            end else if (win_last) begin
              scaler_o <= trig_cnt_inc;
              state    <= ST_ADJUST;
            end else begin
              win_cnt <= win_cnt + COUNTBITS'(1);
            end
          end
          ST_ADJUST: state <= ST_COUNT;
          ST_UPDATE: begin
            busy_o <= 1'b1;
            state  <= ST_HOLDOFF;
          end
          ST_HOLDOFF: begin
            if (ho_last) begin
              state <= enable_i ? ST_COUNT : ST_IDLE;
            end else begin
              ho_cnt <= ho_cnt + HW'(1);
              busy_o <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
        if ((state == ST_UPDATE || state == ST_HOLDOFF) && manual_load_i) begin
          pend_valid <= 1'b1;
          pend_thr   <= manual_threshold_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_glitc_threshold_servo.sv
// tb/tb_glitc_threshold_servo.sv - scoreboard bench for the trigger threshold servo
module tb_glitc_threshold_servo;

  localparam int HOLDOFF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        trig_gen = 1'b0;
  logic        trig_pulse;
  logic [15:0] window, target, deadband;
  logic [13:0] step, thr_min, thr_max, manual_threshold;
  logic        manual_load;
  logic [13:0] threshold;
  logic        threshold_update;
  logic [15:0] scaler;
  logic        busy;
  wire         trig = trig_gen | trig_pulse;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          trig_period = 0;
  int          strobe_cnt = 0;
  int          busy_cnt = 0;
  int          sc1_cnt = 0;
  int          last_strobe_cyc = -1000;
  int          last_gap = 0;
  logic [13:0] prev_thr;
  logic [13:0] exp_q[$];

  glitc_threshold_servo #(.HOLDOFF(HOLDOFF)) dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .enable_i           (enable),
    .trig_i             (trig),
    .window_i           (window),
    .target_i           (target),
    .deadband_i         (deadband),
    .step_i             (step),
    .thr_min_i          (thr_min),
    .thr_max_i          (thr_max),
    .manual_load_i      (manual_load),
    .manual_threshold_i (manual_threshold),
    .threshold_o        (threshold),
    .threshold_update_o (threshold_update),
    .scaler_o           (scaler),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    trig_gen = (trig_period != 0) && (cyc % trig_period == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every strobe pops the next expected threshold
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (threshold !== prev_thr) chk("thr_change_with_strobe", threshold_update, 1);
      if (threshold_update) begin
        if (exp_q.size() == 0) chk("unexpected_strobe", threshold, 14'h3fff);
        else chk("strobe_thr", threshold, exp_q.pop_front());
        if (last_strobe_cyc >= 0) chk("strobe_spacing", (cyc - last_strobe_cyc) >= HOLDOFF + 1, 1);
        last_gap = cyc - last_strobe_cyc;
        last_strobe_cyc = cyc;
        strobe_cnt++;
      end
      if (busy) busy_cnt++;
      if (scaler == 16'd1) sc1_cnt++;
    end
    prev_thr = threshold;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (strobe_cnt < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, strobe_cnt >= n, 1);
  endtask

  task automatic do_load(input logic [13:0] v);
    @(posedge clk);
    #1;
    manual_threshold = v;
    manual_load = 1'b1;
    @(posedge clk);
    #1;
    manual_load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int base, bbase, sbase;
    rst_n = 1'b0; enable = 1'b0; trig_pulse = 1'b0; manual_load = 1'b0;
    window = 16'd100; target = 16'd10; deadband = 16'd2;
    step = 14'd16; thr_min = 14'h0000; thr_max = 14'h3fff; manual_threshold = 14'h0;
    cycles(3);
    rst_n = 1'b1;

    // Reset and idle
    cycles(20);
    chk("reset_thr", threshold, 14'h0800);
    chk("reset_scaler", scaler, 0);
    chk("reset_busy", busy, 0);
    chk("reset_no_strobe", strobe_cnt, 0);

    // Rate too high: 20 trigs per 100-cycle window
    exp_q.push_back(14'h0810);
    exp_q.push_back(14'h0820);
    trig_period = 5;
    enable = 1'b1;
    wait_strobes(2, 600, "wait_rate_high");
    enable = 1'b0;
    trig_period = 0;
    chk("high_scaler", scaler, 20);
    cycles(20);
    chk("high_thr", threshold, 14'h0820);

    // Rate too low with lower clamp
    exp_q.push_back(14'h0800);
    do_load(14'h0800);
    wait_strobes(3, 50, "wait_load_0800");
    cycles(HOLDOFF + 4);
    thr_min = 14'h07F8;
    exp_q.push_back(14'h07F8);
    enable = 1'b1;
    wait_strobes(4, 300, "wait_clamp");
    base = strobe_cnt;
    cycles(350);
    chk("clamp_no_more_strobes", strobe_cnt - base, 0);
    chk("clamp_thr", threshold, 14'h07F8);
    chk("clamp_scaler", scaler, 0);
    enable = 1'b0;
    cycles(5);

    // Inside deadband: 11 trigs per 110-cycle window
    window = 16'd110;
    trig_period = 10;
    base = strobe_cnt;
    bbase = busy_cnt;
    enable = 1'b1;
    cycles(400);
    chk("dead_no_strobe", strobe_cnt - base, 0);
    chk("dead_no_busy", busy_cnt - bbase, 0);
    chk("dead_scaler", scaler, 11);
    enable = 1'b0;
    trig_period = 0;
    cycles(5);

    // Manual load captured during HOLDOFF
    exp_q.push_back(14'h0400);
    do_load(14'h0400);
    wait_strobes(base + 1, 50, "wait_load_0400");
    exp_q.push_back(14'h1234);
    do_load(14'h1234);
    wait_strobes(base + 2, 50, "wait_pending_1234");
    chk("pending_gap", last_gap, HOLDOFF + 1);
    chk("pending_thr", threshold, 14'h1234);
    cycles(HOLDOFF + 4);
    chk("pending_idle_busy", busy, 0);

    // window_i=0: one-cycle windows, trig on final cycle counted
    window = 16'd0;
    target = 16'd1;
    deadband = 16'd1;
    base = strobe_cnt;
    enable = 1'b1;
    cycles(10);
    chk("win0_scaler_idle", scaler, 0);
    sbase = sc1_cnt;
    trig_pulse = 1'b1;
    cycles(2);
    trig_pulse = 1'b0;
    cycles(10);
    chk("win0_scaler_one_for_2cyc", sc1_cnt - sbase, 2);
    chk("win0_no_strobe", strobe_cnt - base, 0);
    enable = 1'b0;
    cycles(5);

    // Reset during HOLDOFF with a pending load aborts the second strobe
    exp_q.push_back(14'h0200);
    do_load(14'h0200);
    wait_strobes(base + 1, 50, "wait_load_0200");
    do_load(14'h0300);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(30);
    chk("abort_thr", threshold, 14'h0800);
    chk("abort_busy", busy, 0);
    chk("abort_scaler", scaler, 0);
    chk("abort_strobes", strobe_cnt - base, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glitc_threshold_servo.md
Name: glitc_threshold_servo

Overview:
- Writer side of the trigger threshold interface: produces the threshold word and the single-cycle update strobe consumed by the DSP power-sum trigger comparator.
- Counts synchronized trigger pulses over a programmable window and steps the threshold up or down to hold a target trigger rate (scaler servo).
- Supports manual threshold loads.
- Runs in the threshold/register clock domain; the trigger path re-synchronizes the strobe into sysclk.

Parameters:
- POWERBITS, 12, power word width; threshold is POWERBITS+2 bits.
- COUNTBITS, 16, width of window, scaler and target fields.
- HOLDOFF, 8, cycles the threshold is held stable after each update strobe so the cross-domain flag completes.
- INIT_THRESHOLD, 14'h0800, threshold value at reset.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- enable_i  in  1  servo enable
- trig_i  in  1  one-cycle trigger pulse, already synchronized to clk_i
- window_i  in  COUNTBITS  window length in cycles; 0 treated as 1
- target_i  in  COUNTBITS  target triggers per window
- deadband_i  in  COUNTBITS  tolerance around target
- step_i  in  POWERBITS+2  threshold step per adjustment
- thr_min_i  in  POWERBITS+2  lower clamp
- thr_max_i  in  POWERBITS+2  upper clamp
- manual_load_i  in  1  load request, one cycle
- manual_threshold_i  in  POWERBITS+2  value to load
- threshold_o  out  POWERBITS+2  threshold to comparator; strictly-greater semantics downstream
- threshold_update_o  out  1  one-cycle strobe, threshold_o valid
- scaler_o  out  COUNTBITS  trigger count of last completed window
- busy_o  out  1  high in UPDATE or HOLDOFF

Behaviour:
- Reset (rst_n_i=0 at clk edge):
  - threshold_o=INIT_THRESHOLD; threshold_update_o=0; scaler_o=0; busy_o=0.
  - Counters 0, pending load cleared, state IDLE.
  - Reset mid-UPDATE/HOLDOFF aborts with no further strobe.
- States: IDLE, COUNT, ADJUST, UPDATE, HOLDOFF.
- IDLE:
  - enable_i=1 -> COUNT with window and trigger counters cleared.
- COUNT:
  - Window counter increments every cycle.
  - trig_i increments the trigger count, saturating at all-ones.
  - When window counter == max(window_i,1)-1: scaler_o <= count, including a trig_i on that final cycle, then -> ADJUST.
  - enable_i=0 -> IDLE; no scaler update.
- ADJUST (one cycle):
  - If count > target_i+deadband_i, computed COUNTBITS+1 wide: new = min(threshold+step_i, thr_max_i), with the sum computed POWERBITS+3 wide.
  - Else if count+deadband_i < target_i: new = max(threshold-step_i, thr_min_i), with underflow clamped to thr_min_i.
  - Else unchanged.
  - If new != threshold_o: threshold_o <= new, -> UPDATE.
  - Else -> COUNT with counters cleared.
- UPDATE:
  - threshold_update_o=1 for exactly this cycle.
  - -> HOLDOFF.
- HOLDOFF:
  - threshold_o frozen for HOLDOFF cycles.
  - Then: if a load is pending -> apply it (threshold_o <= pending, -> UPDATE).
  - Else -> COUNT (counters cleared) if enable_i, else IDLE.
- Manual load:
  - In IDLE, COUNT or ADJUST: threshold_o <= manual_threshold_i next cycle, unclamped; -> UPDATE. Manual load wins over a same-cycle ADJUST result.
  - In UPDATE/HOLDOFF: value captured into pending register. A later request overwrites it (last wins).
- Strobe spacing: at least HOLDOFF+1 cycles between update strobes, always.
- threshold_o changes only on the cycle before a strobe, never otherwise.
- trig_i is ignored outside COUNT.

Decomposition:
- Shared package glitc_trigger_pkg holds:
  - localparam THRBITS = POWERBITS+2;
  - state enum;
  - INIT_THRESHOLD default.
- One sub-module, glitc_sat_counter: a COUNTBITS saturating counter with clear and increment, used for the trigger count.
- Window and holdoff counters stay inline.

Test Plan:
- Reset, then idle 20 cycles -> threshold_o=0x0800, threshold_update_o=0 throughout, scaler_o=0.
- Rate too high: window_i=100, target_i=10, deadband_i=2, step_i=16, 20 trigs/window -> scaler_o=20; threshold_o=0x0810 with one strobe; next window 0x0820.
- Rate too low with clamp: thr_min_i=0x07F8, step_i=16, 0 trigs -> threshold_o=0x07F8; next window no change and no strobe.
- In deadband: 11 trigs, target 10, deadband 2 -> no strobe; COUNT restarts immediately.
- Manual load during HOLDOFF: load 0x1234 two cycles after a strobe -> second strobe exactly HOLDOFF+1 cycles after the first, with threshold_o=0x1234.
- trig_i on the final window cycle plus window_i=0 -> the final-cycle trig is counted, and window_i=0 gives a 1-cycle window with ADJUST every 2 cycles.
